// File: rtl/sdram_cmd_pkg.sv
// Command encoding for the as4c4m16sa user port, shared with the controller wrapper,
// plus the state encoding of the frame streamer sequencer.
package sdram_cmd_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2
    } sdram_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_FILL        = 3'd1,
        ST_STREAM_WAIT = 3'd2,
        ST_STREAM_READ = 3'd3,
        ST_DRAIN       = 3'd4
    } streamer_state_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO with single-cycle flush and occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module stream_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign do_pop    = pop && (count_reg != '0);
    assign do_push   = push && ((count_reg != CW'(DEPTH)) || do_pop);
    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sdram_frame_streamer.sv
// Fills an SDRAM frame region with a test pattern, then loops burst reads over it into a
// stream FIFO. Reads are only issued against free FIFO credits, so the FIFO never overflows.
module sdram_frame_streamer
    import sdram_cmd_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 22,
    parameter int BASE_ADDRESS = 0,
    parameter int FRAME_WORDS  = 307200,
    parameter int BURST_LENGTH = 8,
    parameter int FIFO_DEPTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_fill,
    input  logic                  pattern_mode,
    input  logic [DATA_WIDTH-1:0] pattern_seed,
    input  logic                  start_stream,
    input  logic                  stop,
    output logic                  busy,
    output logic                  fill_done,
    output logic [1:0]            command,
    output logic [ADDR_WIDTH-1:0] data_address,
    output logic [DATA_WIDTH-1:0] data_write,
    input  logic [DATA_WIDTH-1:0] data_read,
    input  logic                  data_read_valid,
    input  logic                  data_write_done,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BURST_LENGTH + 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(BASE_ADDRESS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BASE_ADDRESS + FRAME_WORDS - 1);
    localparam logic [CW-1:0]         DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]         BURST_C   = CW'(BURST_LENGTH);
    localparam logic [BW-1:0]         LAST_BEAT = BW'(BURST_LENGTH - 1);

    generate
        if ((FRAME_WORDS % BURST_LENGTH) != 0) begin : g_bad_frame
            $error("FRAME_WORDS must be a multiple of BURST_LENGTH");
        end
        if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < 2 * BURST_LENGTH)) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of 2 and at least 2*BURST_LENGTH");
        end
    endgenerate

    streamer_state_t        state_reg;
    sdram_cmd_t             command_reg;
    logic [ADDR_WIDTH-1:0]  address_reg;
    logic [DATA_WIDTH-1:0]  data_write_reg;
    logic                   fill_done_reg;
    logic                   mode_reg;
    logic                   stop_pending_reg;
    logic [CW-1:0]          in_flight_reg;
    logic [BW-1:0]          beat_reg;

    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          free_credits;
    logic [DATA_WIDTH:0]    fifo_head;
    logic [ADDR_WIDTH-1:0]  next_address;
    logic                   read_beat;

    // Beats arriving while no read command is outstanding belong to nobody and are dropped.
    assign read_beat    = (command_reg == CMD_READ) && data_read_valid;
    assign next_address = (address_reg == LAST_ADDR) ? BASE_ADDR : address_reg + ADDR_WIDTH'(1);
    assign free_credits = DEPTH_C - fifo_count - in_flight_reg;

    assign busy         = (state_reg != ST_IDLE);
    assign fill_done    = fill_done_reg;
    assign command      = command_reg;
    assign data_address = address_reg;
    assign data_write   = data_write_reg;
    assign out_valid    = (fifo_count != '0);
    assign {out_sof, out_data} = fifo_head;

    stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (read_beat),
        .push_data ({address_reg == BASE_ADDR, data_read}),
        .pop       (out_valid && out_ready),
        .flush     (state_reg == ST_DRAIN),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            command_reg      <= CMD_IDLE;
            address_reg      <= BASE_ADDR;
            data_write_reg   <= '0;
            fill_done_reg    <= 1'b0;
            mode_reg         <= 1'b0;
            stop_pending_reg <= 1'b0;
            in_flight_reg    <= '0;
            beat_reg         <= '0;
        end else begin
            fill_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start_fill) begin
                        state_reg      <= ST_FILL;
                        command_reg    <= CMD_WRITE;
                        address_reg    <= BASE_ADDR;
                        data_write_reg <= pattern_seed;
                        mode_reg       <= pattern_mode;
                    end else if (start_stream) begin
                        state_reg     <= ST_STREAM_WAIT;
                        address_reg   <= BASE_ADDR;
                        in_flight_reg <= '0;
                        beat_reg      <= '0;
                    end
                end
                ST_FILL: begin
                    // Each write gets its own command; one idle cycle separates consecutive writes.
                    if (command_reg == CMD_WRITE) begin
                        if (data_write_done) begin
                            command_reg <= CMD_IDLE;
                            address_reg <= next_address;
                            if (!mode_reg) data_write_reg <= data_write_reg + DATA_WIDTH'(1);
                            if (address_reg == LAST_ADDR) begin
                                state_reg     <= ST_IDLE;
                                fill_done_reg <= 1'b1;
                            end
                        end
                    end else begin
                        command_reg <= CMD_WRITE;
                    end
                end
                ST_STREAM_WAIT: begin
                    if (stop) stop_pending_reg <= 1'b1;
                    if (stop_pending_reg) begin
                        state_reg <= ST_DRAIN;
                    end else if (free_credits >= BURST_C) begin
                        state_reg     <= ST_STREAM_READ;
                        command_reg   <= CMD_READ;
                        in_flight_reg <= in_flight_reg + BURST_C;
                        beat_reg      <= '0;
                    end
                end
                ST_STREAM_READ: begin
                    if (stop) stop_pending_reg <= 1'b1;
                    if (read_beat) begin
                        address_reg   <= next_address;
                        in_flight_reg <= in_flight_reg - CW'(1);
                        beat_reg      <= beat_reg + BW'(1);
                        if (beat_reg == LAST_BEAT) begin
                            command_reg <= CMD_IDLE;
                            state_reg   <= ST_STREAM_WAIT;
                            beat_reg    <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    stop_pending_reg <= 1'b0;
                    state_reg        <= ST_IDLE;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    command_reg <= CMD_IDLE;
                end
            endcase
        end
    end

endmodule
